// File: rtl/ahb_copy_pkg.sv
// Shared types and constants for the AHB-lite block-copy master.
// Optional pattern-fill mode is enabled with the AHB_COPY_FILL_EN macro.
package ahb_copy_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_A,
      ST_RD_D,
      ST_WR_A,
      ST_WR_D,
      ST_ERR
   } state_e;

   localparam logic [2:0]  HSIZE_WORD = 3'b010;
   localparam logic [31:0] ADDR_INC   = 32'd4;

endpackage

// File: rtl/ahb_copy_addr_gen.sv
// Source/destination address pointers and remaining word count for one copy.
// Addresses wrap modulo 2^32; last_o flags the final word of the command.
module ahb_copy_addr_gen
   import ahb_copy_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             load_i,
   input  logic             inc_i,
   input  logic [31:0]      src_i,
   input  logic [31:0]      dst_i,
   input  logic [LEN_W-1:0] len_i,
   output logic [31:0]      src_o,
   output logic [31:0]      dst_o,
   output logic             last_o
);

   logic [31:0]      src_q, src_d;
   logic [31:0]      dst_q, dst_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;

   always_comb begin
      src_d = src_q;
      dst_d = dst_q;
      cnt_d = cnt_q;
      if (load_i) begin
         src_d = src_i;
         dst_d = dst_i;
         cnt_d = len_i;
      end else if (inc_i) begin
         src_d = src_q + ADDR_INC;
         dst_d = dst_q + ADDR_INC;
         cnt_d = cnt_q - LEN_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         src_q <= '0;
         dst_q <= '0;
         cnt_q <= '0;
      end else begin
         src_q <= src_d;
         dst_q <= dst_d;
         cnt_q <= cnt_d;
      end
   end

   assign src_o  = src_q;
   assign dst_o  = dst_q;
   assign last_o = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/ahb_copy_master.sv
// AHB-lite single-transfer master copying word blocks (read word, write word).
// Define AHB_COPY_FILL_EN to add cmd_fill/cmd_pattern for write-only pattern fill.
module ahb_copy_master
   import ahb_copy_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic             hclk,
   input  logic             hreset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [31:0]      cmd_src,
   input  logic [31:0]      cmd_dst,
   input  logic [LEN_W-1:0] cmd_len,
`ifdef AHB_COPY_FILL_EN
   input  logic             cmd_fill,
   input  logic [31:0]      cmd_pattern,
`endif
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [31:0]      err_addr,
   output logic             hsel,
   output logic [31:0]      haddr,
   output logic [2:0]       hsize,
   output logic             hwrite,
   output logic [31:0]      hwdata,
   input  logic [31:0]      hrdata,
   input  logic             hready,
   input  logic             hresp
);

   state_e      state_q, state_d;
   logic [31:0] data_q, data_d;
   logic [31:0] err_addr_q, err_addr_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        ag_load, ag_inc, last_word;
   logic [31:0] src_addr, dst_addr;
   logic        misalign;
   logic        fill_mode;

   ahb_copy_addr_gen #(.LEN_W(LEN_W)) u_addr_gen (
      .clk    (hclk),
      .srst   (hreset),
      .load_i (ag_load),
      .inc_i  (ag_inc),
      .src_i  (cmd_src),
      .dst_i  (cmd_dst),
      .len_i  (cmd_len),
      .src_o  (src_addr),
      .dst_o  (dst_addr),
      .last_o (last_word)
   );

`ifdef AHB_COPY_FILL_EN
   logic fill_q, fill_d;

   always_comb begin
      fill_d = fill_q;
      if (state_q == ST_IDLE && cmd_valid) fill_d = cmd_fill;
   end

   always_ff @(posedge hclk) begin
      if (hreset) fill_q <= 1'b0;
      else        fill_q <= fill_d;
   end

   assign fill_mode = fill_q;
`else
   assign fill_mode = 1'b0;
`endif

   assign misalign = (|cmd_src[1:0]) || (|cmd_dst[1:0]);

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      err_addr_d = err_addr_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      ag_load    = 1'b0;
      ag_inc     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               ag_load    = 1'b1;
               err_addr_d = '0;
               if (misalign) begin
                  // The source address wins when both are misaligned.
                  err_d      = 1'b1;
                  err_addr_d = (|cmd_src[1:0]) ? cmd_src : cmd_dst;
               end else if (cmd_len == '0) begin
                  done_d = 1'b1;
               end else begin
`ifdef AHB_COPY_FILL_EN
                  if (cmd_fill) begin
                     data_d  = cmd_pattern;
                     state_d = ST_WR_A;
                  end else begin
                     state_d = ST_RD_A;
                  end
`else
                  state_d = ST_RD_A;
`endif
               end
            end
         end
         ST_RD_A: if (hready) state_d = ST_RD_D;
         ST_RD_D: begin
            if (hresp) begin
               err_d      = 1'b1;
               err_addr_d = src_addr;
               state_d    = ST_ERR;
            end else if (hready) begin
               data_d  = hrdata;
               state_d = ST_WR_A;
            end
         end
         ST_WR_A: if (hready) state_d = ST_WR_D;
         ST_WR_D: begin
            if (hresp) begin
               err_d      = 1'b1;
               err_addr_d = dst_addr;
               state_d    = ST_ERR;
            end else if (hready) begin
               ag_inc = 1'b1;
               if (last_word) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = fill_mode ? ST_WR_A : ST_RD_A;
               end
            end
         end
         // Sit out the remainder of the slave's two-cycle error response.
         ST_ERR: if (!hresp) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q    <= ST_IDLE;
         data_q     <= '0;
         err_addr_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         err_addr_q <= err_addr_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign err_addr  = err_addr_q;
   assign hsel      = (state_q == ST_RD_A) || (state_q == ST_WR_A);
   assign hwrite    = (state_q == ST_WR_A);
   assign haddr     = (state_q == ST_WR_A) ? dst_addr : src_addr;
   assign hsize     = HSIZE_WORD;
   assign hwdata    = data_q;

endmodule

// File: tb/tb_ahb_copy_master.sv
// Directed bench for ahb_copy_master with a behavioural AHB word-memory slave.
// Slave: addresses 0x4xxx_xxxx give a two-cycle error; optional SRAM-style read wait.
module tb_ahb_copy_master;

   logic        hclk = 1'b0;
   logic        hreset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_src = '0;
   logic [31:0] cmd_dst = '0;
   logic [15:0] cmd_len = '0;
`ifdef AHB_COPY_FILL_EN
   logic        cmd_fill = 1'b0;
   logic [31:0] cmd_pattern = '0;
`endif
   logic        busy, done, err;
   logic [31:0] err_addr;
   logic        hsel, hwrite;
   logic [31:0] haddr, hwdata;
   logic [2:0]  hsize;
   logic [31:0] hrdata;
   logic        hready, hresp;

   always #5 hclk = ~hclk;

   ahb_copy_master #(.LEN_W(16)) dut (
      .hclk      (hclk),
      .hreset    (hreset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_src   (cmd_src),
      .cmd_dst   (cmd_dst),
      .cmd_len   (cmd_len),
`ifdef AHB_COPY_FILL_EN
      .cmd_fill    (cmd_fill),
      .cmd_pattern (cmd_pattern),
`endif
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_addr  (err_addr),
      .hsel      (hsel),
      .haddr     (haddr),
      .hsize     (hsize),
      .hwrite    (hwrite),
      .hwdata    (hwdata),
      .hrdata    (hrdata),
      .hready    (hready),
      .hresp     (hresp)
   );

   // ---------------- slave model ----------------
   logic [31:0] mem [256];
   logic        dp_valid = 1'b0, dp_write = 1'b0, dp_err = 1'b0, err_ph = 1'b0;
   logic        last_wr = 1'b0;
   logic [31:0] dp_addr = '0;
   int          dp_wait = 0;
   logic        sram_mode = 1'b0;
   logic        mem_init = 1'b0;
   int          seed = 0;

   function automatic logic [31:0] init_word(input int idx, input int s);
      return 32'h5A00_0000 ^ (32'(idx) * 32'h0101_0103) ^ (32'(s) << 20);
   endfunction

   always_comb begin
      hready = 1'b1;
      hresp  = 1'b0;
      hrdata = '0;
      if (dp_valid) begin
         if (dp_err) begin
            hresp  = 1'b1;
            hready = err_ph;
         end else if (dp_wait != 0) begin
            hready = 1'b0;
         end else if (!dp_write) begin
            hrdata = mem[dp_addr[9:2]];
         end
      end
   end

   always @(posedge hclk) begin
      if (mem_init)
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i, seed);
      if (dp_valid) begin
         if (dp_err) begin
            if (err_ph) begin
               dp_valid <= 1'b0;
               err_ph   <= 1'b0;
            end else begin
               err_ph <= 1'b1;
            end
         end else if (dp_wait != 0) begin
            dp_wait <= dp_wait - 1;
         end else begin
            if (dp_write) mem[dp_addr[9:2]] <= hwdata;
            dp_valid <= 1'b0;
         end
      end
      if (hsel && hready) begin
         dp_valid <= 1'b1;
         dp_write <= hwrite;
         dp_addr  <= haddr;
         dp_err   <= (haddr[31:28] == 4'h4);
         err_ph   <= 1'b0;
         dp_wait  <= (sram_mode && !hwrite && last_wr) ? 1 : 0;
         last_wr  <= hwrite;
      end
   end

   // ---------------- monitor ----------------
   int          done_cnt = 0;
   int          err_cnt = 0;
   logic [32:0] bus_q [$];

   always @(negedge hclk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (err)  err_cnt  <= err_cnt + 1;
      if (hsel && hready) bus_q.push_back({hwrite, haddr});
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic load_mem(input int s);
      @(negedge hclk);
      seed     = s;
      mem_init = 1'b1;
      @(negedge hclk);
      mem_init = 1'b0;
   endtask

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      logic [15:0] len;
      logic        sram;
      int          exp_k;      // edges after the accept edge until done/err is visible
      int          exp_idle;   // edges after the accept edge until cmd_ready returns
      int          exp_done;
      int          exp_err;
      logic [31:0] exp_err_addr;
      int          exp_bus;    // accepted address phases
   } vec_t;

   localparam int NV = 7;
   vec_t vecs [NV];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int          k, d0, e0, b0, nw;
      logic [31:0] a, sa;
      logic [32:0] exp_q [$];

      vecs[0] = '{32'h2000_0000, 32'h2000_0100, 16'd4, 1'b0, 16, 16, 1, 0, 32'h0, 8};
      vecs[1] = '{32'h2000_0000, 32'h2000_0100, 16'd4, 1'b1, 20, 20, 1, 0, 32'h0, 8};
      vecs[2] = '{32'h2000_0000, 32'h2000_0100, 16'd0, 1'b0,  0,  0, 1, 0, 32'h0, 0};
      vecs[3] = '{32'h2000_0000, 32'h2000_0102, 16'd4, 1'b0,  0,  0, 0, 1, 32'h2000_0102, 0};
      vecs[4] = '{32'h4000_0000, 32'h2000_0000, 16'd2, 1'b0,  2,  4, 0, 1, 32'h4000_0000, 1};
      vecs[5] = '{32'h2000_0001, 32'h2000_0100, 16'd2, 1'b0,  0,  0, 0, 1, 32'h2000_0001, 0};
      vecs[6] = '{32'hFFFF_FFF8, 32'h2000_0040, 16'd3, 1'b0, 12, 12, 1, 0, 32'h0, 6};

      repeat (3) @(posedge hclk);
      #1;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_done",      32'(done),      32'd0);
      check("rst_err",       32'(err),       32'd0);
      check("rst_err_addr",  err_addr,       32'h0);
      check("rst_hsel",      32'(hsel),      32'd0);
      check("rst_haddr",     haddr,          32'h0);
      check("rst_hwrite",    32'(hwrite),    32'd0);
      check("rst_hsize",     32'(hsize),     32'd2);
      check("rst_hwdata",    hwdata,         32'h0);
      hreset = 1'b0;

      for (int v = 0; v < NV; v++) begin
         load_mem(v);
         sram_mode = vecs[v].sram;
         d0 = done_cnt;
         e0 = err_cnt;
         b0 = bus_q.size();
         @(negedge hclk);
         cmd_valid = 1'b1;
         cmd_src   = vecs[v].src;
         cmd_dst   = vecs[v].dst;
         cmd_len   = vecs[v].len;
         @(posedge hclk);
         #1;
         cmd_valid = 1'b0;
         if (vecs[v].exp_bus > 0) begin
            check("first_hsel",  32'(hsel), 32'd1);
            check("first_busy",  32'(busy), 32'd1);
            check("first_haddr", haddr,     vecs[v].src);
         end
         k = 0;
         while (!(done || err) && k < 200) begin
            @(posedge hclk);
            #1;
            k++;
         end
         check("event_cycle", 32'(k), 32'(vecs[v].exp_k));
         while (!cmd_ready && k < 200) begin
            @(posedge hclk);
            #1;
            k++;
         end
         check("idle_cycle", 32'(k), 32'(vecs[v].exp_idle));
         repeat (3) @(posedge hclk);
         #1;
         check("done_pulses", 32'(done_cnt - d0), 32'(vecs[v].exp_done));
         check("err_pulses",  32'(err_cnt - e0),  32'(vecs[v].exp_err));
         if (vecs[v].exp_err != 0) check("err_addr", err_addr, vecs[v].exp_err_addr);

         exp_q.delete();
         if (vecs[v].exp_err == 0) begin
            for (int w = 0; w < int'(vecs[v].len); w++) begin
               exp_q.push_back({1'b0, vecs[v].src + 32'(4 * w)});
               exp_q.push_back({1'b1, vecs[v].dst + 32'(4 * w)});
            end
         end else if (vecs[v].exp_bus == 1) begin
            exp_q.push_back({1'b0, vecs[v].src});
         end
         check("bus_count", 32'(bus_q.size() - b0), 32'(vecs[v].exp_bus));
         for (int i = 0; i < exp_q.size(); i++) begin
            if (b0 + i < bus_q.size()) begin
               check("bus_addr",  bus_q[b0 + i][31:0], exp_q[i][31:0]);
               check("bus_write", 32'(bus_q[b0 + i][32]), 32'(exp_q[i][32]));
            end
         end

         if (vecs[v].exp_done != 0) begin
            for (int w = 0; w < int'(vecs[v].len); w++) begin
               a  = vecs[v].dst + 32'(4 * w);
               sa = vecs[v].src + 32'(4 * w);
               check("dst_data", mem[a[9:2]], init_word(int'(sa[9:2]), v));
            end
         end
         $display("vec %0d: src=%08h dst=%08h len=%0d sram=%0d event@%0d idle@%0d bus=%0d",
                  v, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].sram, k >= 0 ? vecs[v].exp_k : 0,
                  vecs[v].exp_idle, bus_q.size() - b0);
      end

      // Reset while the first write data phase is in flight.
      load_mem(10);
      sram_mode = 1'b0;
      @(negedge hclk);
      cmd_valid = 1'b1;
      cmd_src   = 32'h2000_0000;
      cmd_dst   = 32'h2000_0100;
      cmd_len   = 16'd4;
      @(posedge hclk);
      #1;
      cmd_valid = 1'b0;
      k = 0;
      while (!(hsel && hwrite) && k < 50) begin
         @(posedge hclk);
         #1;
         k++;
      end
      check("rstmid_reach_wr_a", 32'(hsel && hwrite), 32'd1);
      @(posedge hclk);
      #1;
      check("rstmid_wr_d_busy", 32'(busy), 32'd1);
      check("rstmid_wr_d_hsel", 32'(hsel), 32'd0);
      hreset = 1'b1;
      @(posedge hclk);
      #1;
      check("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rstmid_hsel",      32'(hsel),      32'd0);
      check("rstmid_busy",      32'(busy),      32'd0);
      check("rstmid_haddr",     haddr,          32'h0);
      check("rstmid_hwdata",    hwdata,         32'h0);
      check("rstmid_wdata_mem", mem[64],        init_word(0, 10));
      hreset = 1'b0;
      $display("reset-in-WR_D: cmd_ready=%0d hsel=%0d busy=%0d", cmd_ready, hsel, busy);

`ifdef AHB_COPY_FILL_EN
      load_mem(11);
      b0 = bus_q.size();
      d0 = done_cnt;
      @(negedge hclk);
      cmd_valid   = 1'b1;
      cmd_fill    = 1'b1;
      cmd_pattern = 32'hDEAD_BEEF;
      cmd_src     = 32'h0;
      cmd_dst     = 32'h2000_0000;
      cmd_len     = 16'd3;
      @(posedge hclk);
      #1;
      cmd_valid = 1'b0;
      cmd_fill  = 1'b0;
      k = 0;
      while (!done && k < 100) begin
         @(posedge hclk);
         #1;
         k++;
      end
      repeat (3) @(posedge hclk);
      #1;
      check("fill_done",  32'(done_cnt - d0),       32'd1);
      check("fill_bus",   32'(bus_q.size() - b0),   32'd3);
      nw = 0;
      for (int i = b0; i < bus_q.size(); i++) if (bus_q[i][32]) nw++;
      check("fill_writes", 32'(nw), 32'd3);
      for (int w = 0; w < 3; w++) check("fill_data", mem[w], 32'hDEAD_BEEF);
      $display("fill: dst=20000000 len=3 writes=%0d", nw);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
